wb_mem_arbiter: RTL and testbench

//  - Two-master Wishbone (classic, 32-bit) arbiter in front of the single wb port of the on-chip memory wrapper (axi2wb/dpram64 side).
//  - Lets a second requester (e.g. debug/DMA loader) share the memory with the AXI bridge.
//  - Round-robin grant; a grant is held for as long as the granted master holds cyc.
//  - Slave side drives the memory ack/rdt logic unchanged.

---
 rtl/wb_mem_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_wb_mem_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_mem_arbiter.sv
// Two-master round-robin Wishbone classic arbiter in front of a single memory slave port.
// Optional slave watchdog enabled by defining WB_ARB_WDT_EN.
module wb_mem_arbiter #(
  parameter int unsigned AW      = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          i_clk,
  input  logic          i_rst,
  // master 0
  input  logic [AW-3:0] i_m0_adr,
  input  logic [31:0]   i_m0_dat,
  input  logic [3:0]    i_m0_sel,
  input  logic          i_m0_we,
  input  logic          i_m0_cyc,
  input  logic          i_m0_stb,
  output logic [31:0]   o_m0_rdt,
  output logic          o_m0_ack,
  output logic          o_m0_err,
  // master 1
  input  logic [AW-3:0] i_m1_adr,
  input  logic [31:0]   i_m1_dat,
  input  logic [3:0]    i_m1_sel,
  input  logic          i_m1_we,
  input  logic          i_m1_cyc,
  input  logic          i_m1_stb,
  output logic [31:0]   o_m1_rdt,
  output logic          o_m1_ack,
  output logic          o_m1_err,
  // slave
  output logic [AW-3:0] o_s_adr,
  output logic [31:0]   o_s_dat,
  output logic [3:0]    o_s_sel,
  output logic          o_s_we,
  output logic          o_s_cyc,
  output logic          o_s_stb,
  input  logic [31:0]   i_s_rdt,
  input  logic          i_s_ack,
  input  logic          i_s_err,
  output logic [1:0]    o_grant
);

  if (TIMEOUT < 2) begin : g_timeout_chk
    $error("wb_mem_arbiter: TIMEOUT must be >= 2");
  end

  typedef enum logic [1:0] {
    StIdle,
    StGnt0,
    StGnt1
  } state_e;

  state_e     state_q;
  logic       last_q;
  logic [1:0] grant_q;

`ifdef WB_ARB_WDT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] wdt_cnt_q;
  logic            err_q;
  logic            errm_q;
  logic            wdt_expired;

  assign wdt_expired = (wdt_cnt_q == CntW'(TIMEOUT));
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= StIdle;
      last_q    <= 1'b1;
      grant_q   <= 2'b00;
`ifdef WB_ARB_WDT_EN
      wdt_cnt_q <= '0;
      err_q     <= 1'b0;
      errm_q    <= 1'b0;
`endif
    end else begin
`ifdef WB_ARB_WDT_EN
      err_q <= 1'b0;
      // Counter runs only while a strobe waits; any slave response restarts it.
      if (state_q != StIdle) begin
        if (i_s_ack || i_s_err) begin
          wdt_cnt_q <= '0;
        end else if (o_s_stb) begin
          wdt_cnt_q <= wdt_cnt_q + CntW'(1);
        end
      end
`endif
      unique case (state_q)
        StIdle: begin
          if (i_m0_cyc && (!i_m1_cyc || last_q)) begin
            state_q <= StGnt0;
            last_q  <= 1'b0;
            grant_q <= 2'b01;
`ifdef WB_ARB_WDT_EN
            wdt_cnt_q <= '0;
`endif
          end else if (i_m1_cyc) begin
            state_q <= StGnt1;
            last_q  <= 1'b1;
            grant_q <= 2'b10;
`ifdef WB_ARB_WDT_EN
            wdt_cnt_q <= '0;
`endif
          end
        end
        StGnt0: begin
`ifdef WB_ARB_WDT_EN
          if (wdt_expired) begin
            state_q <= StIdle;
            grant_q <= 2'b00;
            err_q   <= 1'b1;
            errm_q  <= 1'b0;
          end else
`endif
          if (!i_m0_cyc) begin
            state_q <= StIdle;
            grant_q <= 2'b00;
          end
        end
        StGnt1: begin
`ifdef WB_ARB_WDT_EN
          if (wdt_expired) begin
            state_q <= StIdle;
            grant_q <= 2'b00;
            err_q   <= 1'b1;
            errm_q  <= 1'b1;
          end else
`endif
          if (!i_m1_cyc) begin
            state_q <= StIdle;
            grant_q <= 2'b00;
          end
        end
        default: begin
          state_q <= StIdle;
          grant_q <= 2'b00;
        end
      endcase
    end
  end

  assign o_grant = grant_q;

  // Slave side is a pure mux of the granted master; responses are gated by grant.
  always_comb begin
    o_s_adr  = '0;
    o_s_dat  = '0;
    o_s_sel  = '0;
    o_s_we   = 1'b0;
    o_s_cyc  = 1'b0;
    o_s_stb  = 1'b0;
    o_m0_rdt = '0;
    o_m0_ack = 1'b0;
    o_m0_err = 1'b0;
    o_m1_rdt = '0;
    o_m1_ack = 1'b0;
    o_m1_err = 1'b0;
    unique case (state_q)
      StGnt0: begin
        o_s_adr  = i_m0_adr;
        o_s_dat  = i_m0_dat;
        o_s_sel  = i_m0_sel;
        o_s_we   = i_m0_we;
        o_s_cyc  = i_m0_cyc;
        o_s_stb  = i_m0_stb;
        o_m0_rdt = i_s_rdt;
        o_m0_ack = i_s_ack;
        o_m0_err = i_s_err;
      end
      StGnt1: begin
        o_s_adr  = i_m1_adr;
        o_s_dat  = i_m1_dat;
        o_s_sel  = i_m1_sel;
        o_s_we   = i_m1_we;
        o_s_cyc  = i_m1_cyc;
        o_s_stb  = i_m1_stb;
        o_m1_rdt = i_s_rdt;
        o_m1_ack = i_s_ack;
        o_m1_err = i_s_err;
      end
      default: ;
    endcase
`ifdef WB_ARB_WDT_EN
    // Timeout error is reported in the idle cycle following the forced release.
    if (err_q) begin
      if (errm_q) begin
        o_m1_err = 1'b1;
      end else begin
        o_m0_err = 1'b1;
      end
    end
`endif
  end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Directed self-checking bench for wb_mem_arbiter; watchdog steps run when WB_ARB_WDT_EN is defined.
module tb_wb_mem_arbiter;

  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-3:0] m0_adr, m1_adr;
  logic [31:0]   m0_dat, m1_dat;
  logic [3:0]    m0_sel, m1_sel;
  logic          m0_we, m1_we, m0_cyc, m1_cyc, m0_stb, m1_stb;
  logic [31:0]   m0_rdt, m1_rdt;
  logic          m0_ack, m1_ack, m0_err, m1_err;
  logic [AW-3:0] s_adr;
  logic [31:0]   s_dat;
  logic [3:0]    s_sel;
  logic          s_we, s_cyc, s_stb;
  logic [31:0]   s_rdt;
  logic          s_ack = 1'b0;
  logic          s_err;
  logic [1:0]    grant;

  logic          ack_en;
  int            checks = 0;
  int            errors = 0;
  int            n_ack0, n_ack1;
  logic [1:0]    exp_gnt [12];

  always #5 clk = ~clk;

  // Memory-like slave: ack one cycle after a strobe, never two in a row.
  always @(posedge clk) s_ack <= ack_en && s_cyc && s_stb && !s_ack;
  assign s_rdt = {16'hC0DE, 2'b00, s_adr};

  wb_mem_arbiter #(
    .AW      (AW),
    .TIMEOUT (8)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_m0_adr (m0_adr),
    .i_m0_dat (m0_dat),
    .i_m0_sel (m0_sel),
    .i_m0_we  (m0_we),
    .i_m0_cyc (m0_cyc),
    .i_m0_stb (m0_stb),
    .o_m0_rdt (m0_rdt),
    .o_m0_ack (m0_ack),
    .o_m0_err (m0_err),
    .i_m1_adr (m1_adr),
    .i_m1_dat (m1_dat),
    .i_m1_sel (m1_sel),
    .i_m1_we  (m1_we),
    .i_m1_cyc (m1_cyc),
    .i_m1_stb (m1_stb),
    .o_m1_rdt (m1_rdt),
    .o_m1_ack (m1_ack),
    .o_m1_err (m1_err),
    .o_s_adr  (s_adr),
    .o_s_dat  (s_dat),
    .o_s_sel  (s_sel),
    .o_s_we   (s_we),
    .o_s_cyc  (s_cyc),
    .o_s_stb  (s_stb),
    .i_s_rdt  (s_rdt),
    .i_s_ack  (s_ack),
    .i_s_err  (s_err),
    .o_grant  (grant)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    exp_gnt = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00,
                2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00};
    rst    = 1'b1;
    ack_en = 1'b0;
    s_err  = 1'b0;
    m0_adr = '0; m0_dat = '0; m0_sel = '0; m0_we = 1'b0; m0_cyc = 1'b1; m0_stb = 1'b0;
    m1_adr = '0; m1_dat = '0; m1_sel = '0; m1_we = 1'b0; m1_cyc = 1'b1; m1_stb = 1'b0;

    // Reset held three cycles with both masters requesting
    tick();
    chk("rst_grant", grant, 2'b00);
    chk("rst_s_cyc", s_cyc, 1'b0);
    chk("rst_s_stb", s_stb, 1'b0);
    chk("rst_s_bus", {s_adr, s_dat, s_sel, s_we}, '0);
    chk("rst_m_resp", {m0_ack, m0_err, m1_ack, m1_err}, 4'b0000);
    chk("rst_m_rdt", m0_rdt | m1_rdt, 32'h0);
    tick();
    tick();
    chk("rst_grant_end", grant, 2'b00);
    rst = 1'b0;
    tick();
    chk("first_grant_m0", grant, 2'b01);
    chk("first_s_cyc", s_cyc, 1'b1);
    m0_cyc = 1'b0;
    m1_cyc = 1'b0;
    tick();
    chk("first_release", grant, 2'b00);

    // Single master write from m1
    ack_en = 1'b1;
    m1_adr = 14'h0010; m1_dat = 32'hDEADBEEF; m1_sel = 4'hF; m1_we = 1'b1;
    m1_cyc = 1'b1; m1_stb = 1'b1;
    tick();
    chk("wr_grant", grant, 2'b10);
    chk("wr_s_adr", s_adr, 14'h0010);
    chk("wr_s_dat", s_dat, 32'hDEADBEEF);
    chk("wr_s_sel", s_sel, 4'hF);
    chk("wr_s_we_cyc_stb", {s_we, s_cyc, s_stb}, 3'b111);
    chk("wr_m1_ack_early", m1_ack, 1'b0);
    tick();
    chk("wr_m1_ack", m1_ack, 1'b1);
    chk("wr_m0_ack", m0_ack, 1'b0);
    m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0;
    tick();
    chk("wr_m1_ack_once", m1_ack, 1'b0);
    chk("wr_release", grant, 2'b00);

    // Contention: each master drops cyc for one cycle after its ack
    m0_adr = 14'h0004; m1_adr = 14'h0008;
    m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
    n_ack0 = 0;
    n_ack1 = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk($sformatf("rr_grant_%0d", i), grant, exp_gnt[i]);
      if (m0_ack) begin
        n_ack0++;
        chk("rr_m0_rdt", m0_rdt, 32'hC0DE0004);
        chk("rr_m1_rdt_gated", m1_rdt, 32'h0);
      end
      if (m1_ack) begin
        n_ack1++;
        chk("rr_m1_rdt", m1_rdt, 32'hC0DE0008);
      end
      m0_cyc = !m0_ack; m0_stb = !m0_ack;
      m1_cyc = !m1_ack; m1_stb = !m1_ack;
    end
    m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
    tick();
    chk("rr_m0_acks", n_ack0, 2);
    chk("rr_m1_acks", n_ack1, 2);

    // Lock: m0 keeps cyc over four beats while m1 waits
    m0_adr = 14'h0020; m1_adr = 14'h0030;
    m0_cyc = 1'b1; m0_stb = 1'b1; m1_cyc = 1'b1; m1_stb = 1'b1;
    n_ack0 = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("lock_grant_%0d", i), grant, 2'b01);
      chk("lock_m1_ack", m1_ack, 1'b0);
      if (m0_ack) n_ack0++;
    end
    chk("lock_beats", n_ack0, 4);
    m0_cyc = 1'b0; m0_stb = 1'b0;
    tick();
    chk("lock_bubble", grant, 2'b00);
    tick();
    chk("lock_m1_grant", grant, 2'b10);
    chk("lock_m1_s_adr", s_adr, 14'h0030);

    // Reset in the middle of the m1 transfer; the late slave ack is dropped
    rst = 1'b1;
    tick();
    chk("mid_rst_s_cyc", s_cyc, 1'b0);
    chk("mid_rst_grant", grant, 2'b00);
    chk("mid_rst_m1_ack", m1_ack, 1'b0);
    rst = 1'b0;
    m1_cyc = 1'b0; m1_stb = 1'b0;
    tick();

    // Slave error passthrough to the granted master only
    ack_en = 1'b0;
    m0_cyc = 1'b1; m0_stb = 1'b1;
    tick();
    chk("err_grant", grant, 2'b01);
    s_err = 1'b1;
    #1;
    chk("err_m0", m0_err, 1'b1);
    chk("err_m1_gated", m1_err, 1'b0);
    s_err = 1'b0;
    m0_cyc = 1'b0; m0_stb = 1'b0;
    tick();
    chk("err_release", grant, 2'b00);

`ifdef WB_ARB_WDT_EN
    // Watchdog: slave never answers, TIMEOUT = 8
    m0_cyc = 1'b1; m0_stb = 1'b1;
    tick();
    chk("wdt_grant", grant, 2'b01);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("wdt_wait_%0d", k), {grant, m0_err}, {2'b01, 1'b0});
    end
    tick();
    chk("wdt_err_pulse", m0_err, 1'b1);
    chk("wdt_m1_err", m1_err, 1'b0);
    chk("wdt_idle", grant, 2'b00);
    chk("wdt_s_cyc", {s_cyc, s_stb}, 2'b00);
    tick();
    chk("wdt_err_clear", m0_err, 1'b0);
    chk("wdt_regrant", grant, 2'b01);
    m0_cyc = 1'b0; m0_stb = 1'b0;
    tick();
    chk("wdt_release", grant, 2'b00);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
